// File: rtl/ram_burst_reader.sv
// Burst read client for a RAMMEM read port: walks a wrapping address range and streams
// the words out through a 2-entry FIFO with valid/ready backpressure.
module ram_burst_reader #(
    parameter int ADDR_BITS = 4,
    parameter int WIDTH     = 10,
    parameter int SYNC_READ = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [ADDR_BITS-1:0] req_len,
    output logic                 mem_read_en,
    output logic [ADDR_BITS-1:0] mem_read_addr,
    input  logic [WIDTH-1:0]     mem_read_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic                 done
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   cur_addr_q, cur_addr_d;
    logic [ADDR_BITS-1:0]   issue_left_q, issue_left_d;
    logic                   issue_pend_q, issue_pend_d;
    logic [ADDR_BITS-1:0]   pop_left_q, pop_left_d;
    logic [ADDR_BITS-1:0]   last_addr_q, last_addr_d;
    logic                   inflight_q, inflight_d;
    logic                   done_q, done_d;
    logic [1:0]             count_q, count_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]       fifo_data_q [2];
    logic [1:0]             fifo_wr_en;

    logic                   pop;
    logic                   push;
    logic                   issue;
    logic [2:0]             occupancy;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = fifo_data_q[rd_ptr_q];
    assign out_last  = out_valid && (pop_left_q == '0);
    assign pop       = out_valid && out_ready;
    assign req_ready = (state_q == IDLE);
    assign done      = done_q;

    // Words already buffered plus the one still coming out of a sync memory; a word
    // leaving this cycle frees its slot immediately.
    assign occupancy   = {1'b0, count_q} + {2'b00, inflight_q};
    assign issue       = (state_q == BUSY) && issue_pend_q &&
                         (occupancy < (3'd2 + {2'b00, pop}));
    assign mem_read_en   = issue;
    assign mem_read_addr = issue ? cur_addr_q : last_addr_q;

    assign push       = (SYNC_READ != 0) ? inflight_q : issue;
    assign inflight_d = (SYNC_READ != 0) && issue;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_wr
        assign fifo_wr_en[gi] = push && (wr_ptr_q == 1'(gi));
    end

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        issue_left_d = issue_left_q;
        issue_pend_d = issue_pend_q;
        pop_left_d   = pop_left_q;
        last_addr_d  = last_addr_q;
        done_d       = 1'b0;
        count_d      = count_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d     = wr_ptr_q ^ push;
        rd_ptr_d     = rd_ptr_q ^ pop;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d      = BUSY;
                    cur_addr_d   = req_addr;
                    issue_left_d = req_len;
                    pop_left_d   = req_len;
                    issue_pend_d = 1'b1;
                end
            end
            BUSY: begin
                if (issue) begin
                    cur_addr_d  = cur_addr_q + ADDR_BITS'(1);
                    last_addr_d = cur_addr_q;
                    if (issue_left_q == '0) begin
                        issue_pend_d = 1'b0;
                    end else begin
                        issue_left_d = issue_left_q - ADDR_BITS'(1);
                    end
                end
                if (pop) begin
                    if (pop_left_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        pop_left_d = pop_left_q - ADDR_BITS'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            issue_left_q <= '0;
            issue_pend_q <= 1'b0;
            pop_left_q   <= '0;
            last_addr_q  <= '0;
            inflight_q   <= 1'b0;
            done_q       <= 1'b0;
            count_q      <= 2'd0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            issue_left_q <= issue_left_d;
            issue_pend_q <= issue_pend_d;
            pop_left_q   <= pop_left_d;
            last_addr_q  <= last_addr_d;
            inflight_q   <= inflight_d;
            done_q       <= done_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // FIFO storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (fifo_wr_en[i]) begin
                fifo_data_q[i] <= mem_read_data;
            end
        end
    end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Random and directed bursts against both read modes; a burst-level model predicts
// addresses, words, last flags and done pulses every cycle.
module tb_ram_burst_reader;
    localparam int AB    = 4;
    localparam int W     = 10;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst       [2];
    logic           req_valid [2];
    logic           req_ready [2];
    logic [AB-1:0]  req_addr  [2];
    logic [AB-1:0]  req_len   [2];
    logic           mem_en    [2];
    logic [AB-1:0]  mem_addr  [2];
    logic [W-1:0]   mem_rdata [2];
    logic           out_valid [2];
    logic           out_ready [2];
    logic [W-1:0]   out_data  [2];
    logic           out_last  [2];
    logic           done      [2];

    logic [W-1:0]   mem_arr [DEPTH];
    logic [W-1:0]   sync_rd_q;

    // Instance 0 sees a combinational memory, instance 1 a registered one.
    assign mem_rdata[0] = mem_arr[mem_addr[0]];
    always @(posedge clk) if (mem_en[1]) sync_rd_q <= mem_arr[mem_addr[1]];
    assign mem_rdata[1] = sync_rd_q;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        ram_burst_reader #(.ADDR_BITS(AB), .WIDTH(W), .SYNC_READ(gi)) dut (
            .clock         (clk),
            .reset         (rst[gi]),
            .req_valid     (req_valid[gi]),
            .req_ready     (req_ready[gi]),
            .req_addr      (req_addr[gi]),
            .req_len       (req_len[gi]),
            .mem_read_en   (mem_en[gi]),
            .mem_read_addr (mem_addr[gi]),
            .mem_read_data (mem_rdata[gi]),
            .out_valid     (out_valid[gi]),
            .out_ready     (out_ready[gi]),
            .out_data      (out_data[gi]),
            .out_last      (out_last[gi]),
            .done          (done[gi])
        );
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    int busy [2]        = '{0, 0};
    int base [2]        = '{0, 0};
    int blen [2]        = '{0, 0};
    int issued [2]      = '{0, 0};
    int popped [2]      = '{0, 0};
    int last_addr [2]   = '{0, 0};
    int done_exp [2]    = '{0, 0};
    int done_cnt [2]    = '{0, 0};
    int max_out [2]     = '{0, 0};
    int accept_cyc [2]  = '{0, 0};
    int first_valid [2] = '{-1, -1};
    int first_pop [2]   = '{-1, -1};
    int last_pop [2]    = '{-1, -1};
    int log_data [2][16];
    int log_addr [2][16];

    task automatic chk(input string name, input int m, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s mode=%0d cyc=%0d got=%0d expected=%0d", name, m, cyc, act, exp);
        end
    endtask

    function automatic int mem_at(input int a);
        logic [AB-1:0] ai;
        ai = AB'(a % DEPTH);
        return int'(mem_arr[ai]);
    endfunction

    // Burst-level reference: the k-th issued address is base+k, the k-th popped word is
    // mem[base+k], last when k==len, done the cycle after the last pop.
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (rst[m]) begin
                busy[m] = 0; done_exp[m] = 0; last_addr[m] = 0;
                issued[m] = 0; popped[m] = 0;
            end else begin
                chk("req_ready", m, int'(req_ready[m]), busy[m] != 0 ? 0 : 1);
                chk("done", m, int'(done[m]), done_exp[m]);
                if (done[m]) done_cnt[m]++;
                done_exp[m] = 0;
                if (out_valid[m]) begin
                    if (first_valid[m] < 0) first_valid[m] = cyc;
                    chk("word_avail", m, int'(busy[m] != 0 && popped[m] < issued[m]), 1);
                    if (busy[m] != 0) begin
                        chk("out_data", m, int'(out_data[m]), mem_at(base[m] + popped[m]));
                        chk("out_last", m, int'(out_last[m]), int'(popped[m] == blen[m]));
                    end
                    if (out_ready[m]) begin
                        log_data[m][popped[m] % 16] = int'(out_data[m]);
                        if (first_pop[m] < 0) first_pop[m] = cyc;
                        last_pop[m] = cyc;
                        popped[m]++;
                        if (popped[m] > blen[m]) begin
                            busy[m] = 0;
                            done_exp[m] = 1;
                        end
                    end
                end
                if (mem_en[m]) begin
                    chk("issue_in_burst", m, int'(issued[m] <= blen[m] && issued[m] >= popped[m]), 1);
                    chk("rd_addr", m, int'(mem_addr[m]), (base[m] + issued[m]) % DEPTH);
                    log_addr[m][issued[m] % 16] = int'(mem_addr[m]);
                    last_addr[m] = int'(mem_addr[m]);
                    issued[m]++;
                end else begin
                    chk("rd_addr_hold", m, int'(mem_addr[m]), last_addr[m]);
                end
                if (issued[m] - popped[m] > max_out[m]) max_out[m] = issued[m] - popped[m];
                if (busy[m] != 0) chk("buffered_le_2", m, int'(issued[m] - popped[m] <= 2), 1);
                if (req_valid[m] && req_ready[m]) begin
                    busy[m] = 1; base[m] = int'(req_addr[m]); blen[m] = int'(req_len[m]);
                    issued[m] = 0; popped[m] = 0; max_out[m] = 0; done_cnt[m] = 0;
                    accept_cyc[m] = cyc; first_valid[m] = -1;
                    first_pop[m] = -1; last_pop[m] = -1;
                end
            end
        end
    end

    // rmode: 0 always ready, 1 random ready, 2 six-cycle stall early in the burst
    task automatic run_burst(input int m, input int addr, input int len, input int rmode);
        int n;
        @(posedge clk); #1;
        req_valid[m] = 1'b1;
        req_addr[m]  = AB'(addr);
        req_len[m]   = AB'(len);
        out_ready[m] = 1'b1;
        @(posedge clk); #1;
        req_valid[m] = 1'b0;
        req_addr[m]  = AB'($urandom_range(0, 15));
        req_len[m]   = AB'($urandom_range(0, 15));
        n = 0;
        while (busy[m] != 0 && n < 300) begin
            case (rmode)
                1:       out_ready[m] = 1'($urandom_range(0, 1));
                2:       out_ready[m] = (n >= 2 && n < 8) ? 1'b0 : 1'b1;
                default: out_ready[m] = 1'b1;
            endcase
            @(posedge clk); #1;
            n++;
        end
        chk("burst_timeout", m, int'(n < 300), 1);
        out_ready[m] = 1'b1;
        @(negedge clk); #1;
        chk("done_once", m, done_cnt[m], 1);
        chk("words_delivered", m, popped[m], len + 1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) mem_arr[i] = W'(i + 100);
        for (int m = 0; m < 2; m++) begin
            rst[m] = 1'b1; req_valid[m] = 1'b0; out_ready[m] = 1'b0;
            req_addr[m] = '0; req_len[m] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) rst[m] = 1'b0;
        @(negedge clk); #1;
        for (int m = 0; m < 2; m++) begin
            chk("rst_out_valid", m, int'(out_valid[m]), 0);
            chk("rst_out_last", m, int'(out_last[m]), 0);
            chk("rst_mem_en", m, int'(mem_en[m]), 0);
            chk("rst_mem_addr", m, int'(mem_addr[m]), 0);
            chk("rst_done", m, int'(done[m]), 0);
            chk("rst_req_ready", m, int'(req_ready[m]), 1);
        end

        for (int m = 0; m < 2; m++) begin
            // wrap burst 14,15,0,1
            run_burst(m, 14, 3, 0);
            chk("wrap_d0", m, log_data[m][0], 114);
            chk("wrap_d1", m, log_data[m][1], 115);
            chk("wrap_d2", m, log_data[m][2], 100);
            chk("wrap_d3", m, log_data[m][3], 101);
            chk("wrap_a0", m, log_addr[m][0], 14);
            chk("wrap_a2", m, log_addr[m][2], 0);
            chk("wrap_a3", m, log_addr[m][3], 1);
            chk("latency", m, first_valid[m] - accept_cyc[m], 2 + m);
            chk("no_gaps", m, last_pop[m] - first_pop[m], 3);

            run_burst(m, 5, 0, 0);
            chk("single_word", m, log_data[m][0], 105);
            chk("single_issue", m, issued[m], 1);

            run_burst(m, 3, 7, 2);
            chk("stall_max_buffered", m, max_out[m], 2);
            for (int k = 0; k < 8; k++) chk("stall_order", m, log_data[m][k], 100 + (3 + k) % 16);

            run_burst(m, 0, 15, 0);
            chk("full_no_gaps", m, last_pop[m] - first_pop[m], 15);

            for (int r = 0; r < 6; r++) begin
                for (int i = 0; i < DEPTH; i++) mem_arr[i] = W'($urandom_range(0, 1023));
                run_burst(m, int'($urandom_range(0, 15)), (r < 3) ? 15 : int'($urandom_range(0, 15)), 1);
            end
            for (int i = 0; i < DEPTH; i++) mem_arr[i] = W'(i + 100);

            // reset after the second word of a len=7 burst
            @(posedge clk); #1;
            req_valid[m] = 1'b1; req_addr[m] = AB'(2); req_len[m] = AB'(7); out_ready[m] = 1'b1;
            @(posedge clk); #1;
            req_valid[m] = 1'b0;
            n = 0;
            while (popped[m] < 2 && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            chk("rst_burst_timeout", m, int'(n < 50), 1);
            rst[m] = 1'b1;
            @(posedge clk); #1;
            rst[m] = 1'b0;
            @(negedge clk); #1;
            chk("midrst_out_valid", m, int'(out_valid[m]), 0);
            chk("midrst_req_ready", m, int'(req_ready[m]), 1);
            chk("midrst_done", m, int'(done[m]), 0);
            repeat (3) @(posedge clk);
            run_burst(m, 9, 4, 0);
            chk("post_rst_d0", m, log_data[m][0], 109);
            chk("post_rst_d4", m, log_data[m][4], 113);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
